// File: rtl/os_ctrl_pkg.sv
// rtl/os_ctrl_pkg.sv - shared state encoding and op-codes for the OS tile sequencer
package os_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, BIAS, GAP, FLOW, SKEW, DWAIT, DSTORE, DONE
  } state_t;

  localparam logic [2:0] OP_IDLE     = 3'b000;
  localparam logic [2:0] OP_OS_FLOW  = 3'b100;
  localparam logic [2:0] OP_OS_DRAIN = 3'b110;

  function automatic logic [2:0] op_for(input state_t s);
    case (s)
      FLOW, SKEW:     return OP_OS_FLOW;
      DWAIT, DSTORE:  return OP_OS_DRAIN;
      default:        return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/os_phase_counter.sv
// rtl/os_phase_counter.sv - loadable phase down-counter with zero-length-skip flag
module os_phase_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] alt_val,
  output logic             last,
  output logic             skip
);

  logic [WIDTH-1:0] cnt;

  // A non-positive length means the phase vanishes; the following phase length is loaded instead.
  assign skip = load_val[WIDTH-1] || (load_val == '0);
  assign last = (cnt == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= skip ? alt_val : load_val;
    else if (cnt != '0)
      cnt <= cnt - WIDTH'(1);
  end

endmodule

// File: rtl/os_tile_controller.sv
// rtl/os_tile_controller.sv - OS-mode tile sequencer driving systolic_system control ports
module os_tile_controller import os_ctrl_pkg::*; #(
  parameter int ARRAY_N      = 16,
  parameter int ARRAY_M      = 16,
  parameter int PE_OUT_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DIM_WIDTH    = 32,
  localparam int IW          = $clog2(ARRAY_N) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIM_WIDTH-1:0]    cfg_m,
  input  logic [DIM_WIDTH-1:0]    cfg_k,
  input  logic [DIM_WIDTH-1:0]    cfg_n,
  input  logic [ADDR_WIDTH-1:0]   cfg_a_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_w_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_o_base,
  output logic [IW-1:0]           bias_rd_idx,
  input  logic [PE_OUT_WIDTH-1:0] bias_rd_data,
  output logic                    mode,
  output logic                    a_buf_on,
  output logic [ADDR_WIDTH-1:0]   a_base_addr,
  output logic [IW-1:0]           a_num_rows,
  output logic                    w_buf_on,
  output logic [ADDR_WIDTH-1:0]   w_base_addr,
  output logic [IW-1:0]           w_num_cols,
  output logic [2:0]              operation_signal_in,
  output logic [IW-1:0]           w_index_bias,
  output logic [PE_OUT_WIDTH-1:0] w_data_bias,
  output logic                    w_en_bias,
  output logic                    o_ag_o_on,
  output logic [ADDR_WIDTH-1:0]   o_base_addr,
  output logic [DIM_WIDTH-1:0]    M,
  output logic [DIM_WIDTH-1:0]    K,
  output logic [DIM_WIDTH-1:0]    N,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam logic [DIM_WIDTH-1:0] ONE    = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0] ROWS_N = DIM_WIDTH'(ARRAY_N);
  localparam logic [DIM_WIDTH-1:0] COLS_M = DIM_WIDTH'(ARRAY_M);

  state_t                 state, state_next;
  logic                   legal, accept;
  logic                   cnt_load, cnt_last, cnt_skip;
  logic [DIM_WIDTH-1:0]   cnt_val, cnt_alt;

  assign legal  = (cfg_m != '0) && (cfg_m <= ROWS_N) &&
                  (cfg_n != '0) && (cfg_n <= COLS_M) && (cfg_k != '0);
  assign accept = (state == IDLE) && start && legal;

  // Length of the phase that follows the current one; phase lengths use latched M/K/N only.
  always_comb begin
    cnt_val = ROWS_N;
    case (state)
      BIAS:    cnt_val = ONE;
      GAP:     cnt_val = K;
      FLOW:    cnt_val = M + N - ONE;
      SKEW:    cnt_val = ROWS_N - M - ONE;
      DWAIT:   cnt_val = M + ONE;
      DSTORE:  cnt_val = ONE;
      default: cnt_val = ROWS_N;
    endcase
  end

  assign cnt_alt  = M + ONE;
  assign cnt_load = accept || ((state != IDLE) && (state != DONE) && cnt_last);

  os_phase_counter #(.WIDTH(DIM_WIDTH)) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .alt_val  (cnt_alt),
    .last     (cnt_last),
    .skip     (cnt_skip)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = BIAS;
      BIAS:    if (cnt_last) state_next = GAP;
      GAP:     if (cnt_last) state_next = FLOW;
      FLOW:    if (cnt_last) state_next = SKEW;
      SKEW:    if (cnt_last) state_next = cnt_skip ? DSTORE : DWAIT;
      DWAIT:   if (cnt_last) state_next = DSTORE;
      DSTORE:  if (cnt_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next so each reflects the phase it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= 1'b0; busy <= 1'b0; done <= 1'b0; cfg_err <= 1'b0;
      a_buf_on <= 1'b0; w_buf_on <= 1'b0; o_ag_o_on <= 1'b0; w_en_bias <= 1'b0;
      operation_signal_in <= OP_IDLE;
      bias_rd_idx <= '0; w_index_bias <= '0; w_data_bias <= '0;
      a_base_addr <= '0; w_base_addr <= '0; o_base_addr <= '0;
      a_num_rows <= '0; w_num_cols <= '0; M <= '0; K <= '0; N <= '0;
    end else begin
      mode                <= (state_next != IDLE);
      busy                <= (state_next != IDLE);
      done                <= (state_next == DONE);
      cfg_err             <= (state == IDLE) && start && !legal;
      a_buf_on            <= (state_next == FLOW);
      w_buf_on            <= (state_next == FLOW);
      o_ag_o_on           <= (state_next == DSTORE);
      w_en_bias           <= (state_next == BIAS);
      operation_signal_in <= op_for(state_next);

      // The read index runs one entry ahead so the registered index and data stay paired.
      if (state_next == BIAS) begin
        w_index_bias <= bias_rd_idx;
        w_data_bias  <= bias_rd_data;
        bias_rd_idx  <= (bias_rd_idx == IW'(ARRAY_N - 1)) ? '0 : bias_rd_idx + IW'(1);
      end else begin
        w_index_bias <= '0;
        w_data_bias  <= '0;
        bias_rd_idx  <= '0;
      end

      if (accept) begin
        M <= cfg_m; K <= cfg_k; N <= cfg_n;
        a_num_rows  <= cfg_m[IW-1:0];
        w_num_cols  <= cfg_n[IW-1:0];
        a_base_addr <= cfg_a_base;
        w_base_addr <= cfg_w_base;
        o_base_addr <= cfg_o_base;
      end else if (state_next == IDLE) begin
        M <= '0; K <= '0; N <= '0;
        a_num_rows <= '0; w_num_cols <= '0;
        a_base_addr <= '0; w_base_addr <= '0; o_base_addr <= '0;
      end
    end
  end

endmodule
